memory_stage: RTL and testbench

Pipeline Memory stage of the LA32 in-order core, between Execute and Writeback. Latches Execute's segment outputs and runs a load/store on the data-memory request/response bus. Byte/half loads are aligned and sign/zero-extended here, and stores get byte strobes. Writeback receives final `ex_result`, `mem_result`, `rd_index`, `number_length`, `writeback_valid` and `writeback_src`. Upstream is stalled while an access is outstanding.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/memory_stage_if.sv | 21 ++
 rtl/load_align.sv | 45 ++++
 rtl/memory_stage.sv | 183 ++++++++++++++++++
 tb/tb_memory_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared LA32 core definitions: access size/sign encodings, memory-stage
// FSM states, writeback source selects and the misalignment rule.
package core_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // number_length[2] selects zero extension for loads
    localparam int unsigned NL_UNSIGNED_BIT = 2;

    localparam logic WB_SRC_EX  = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Instruction held by the memory stage; all-zero is a bubble
    typedef struct packed {
        logic [31:0] ex_result;
        logic [31:0] store_data;
        logic [4:0]  rd_index;
        logic [2:0]  number_length;
        logic        mem_read;
        logic        mem_write;
        logic        wb_valid;
        logic        wb_src;
        logic        ale;
    } held_t;

    // Half needs addr[0]=0, word (and reserved size) needs addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic mis;
        case (size_e'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr[0];
            default:   mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and memory.
interface memory_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  number_length,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sign_s;

    // Pick the addressed lane, then extend it to 32 bits
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        sign_s = 1'b0;
        result = 32'h0000_0000;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size_e'(number_length[1:0]))
            SIZE_BYTE: begin
                sign_s = !number_length[NL_UNSIGNED_BIT] && byte_s[7];
                result = {{24{sign_s}}, byte_s};
            end
            SIZE_HALF: begin
                sign_s = !number_length[NL_UNSIGNED_BIT] && half_s[15];
                result = {{16{sign_s}}, half_s};
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// LA32 memory stage: holds the Execute result, runs one data-memory access
// at a time, aligns load data and presents the result to Writeback.
module memory_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ex_result_RegInput,
    input  logic [31:0] store_data_RegInput,
    input  logic [4:0]  rd_index_RegInput,
    input  logic [2:0]  number_length_RegInput,
    input  logic        mem_read_RegInput,
    input  logic        mem_write_RegInput,
    input  logic        writeback_valid_RegInput,
    input  logic        writeback_src_RegInput,
    input  logic        clear_RegInput,
    output logic        stall,
    memory_stage_if.master dmem,
    output logic [31:0] ex_result,
    output logic [31:0] mem_result,
    output logic [4:0]  rd_index,
    output logic [2:0]  number_length,
    output logic        writeback_valid,
    output logic        writeback_src,
    output logic        ale
);

    state_e      state_r;
    state_e      state_nx;
    held_t       held_r;
    logic [31:0] rdata_r;
    logic        capture_s;
    logic        bubble_s;
    logic        latch_s;
    logic        mem_op_in_s;
    logic        misaligned_in_s;
    logic [31:0] align_s;

    assign mem_op_in_s     = mem_read_RegInput | mem_write_RegInput;
    assign misaligned_in_s = is_misaligned(number_length_RegInput[1:0], ex_result_RegInput[1:0]);

    // Sequencer next state plus the capture / flush / response-latch strobes
    always_comb begin
        state_nx  = state_r;
        capture_s = 1'b0;
        bubble_s  = 1'b0;
        latch_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (clear_RegInput) begin
                    bubble_s = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    capture_s = 1'b1;
                    if (mem_op_in_s) begin
                        state_nx = misaligned_in_s ? ST_DONE : ST_REQ;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_REQ: begin
                // Request not yet accepted, so a flush can simply drop it
                if (clear_RegInput) begin
                    bubble_s = 1'b1;
                    state_nx = ST_IDLE;
                end else if (dmem.dmem_req_ready) begin
                    state_nx = ST_RESP;
                end else begin
                    state_nx = ST_REQ;
                end
            end
            ST_RESP: begin
                // Accepted request must still see its response before moving on
                if (clear_RegInput) begin
                    bubble_s = 1'b1;
                    state_nx = ST_DRAIN;
                end else if (dmem.dmem_rsp_valid) begin
                    latch_s  = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (dmem.dmem_rsp_valid) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Held instruction and latched load data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held_r  <= '0;
            rdata_r <= 32'h0000_0000;
        end else if (bubble_s) begin
            held_r  <= '0;
            rdata_r <= 32'h0000_0000;
        end else if (capture_s) begin
            held_r.ex_result     <= ex_result_RegInput;
            held_r.store_data    <= store_data_RegInput;
            held_r.rd_index      <= rd_index_RegInput;
            held_r.number_length <= number_length_RegInput;
            held_r.mem_read      <= mem_read_RegInput;
            held_r.mem_write     <= mem_write_RegInput;
            held_r.wb_valid      <= writeback_valid_RegInput;
            held_r.wb_src        <= writeback_src_RegInput;
            held_r.ale           <= mem_op_in_s & misaligned_in_s;
            rdata_r              <= 32'h0000_0000;
        end else if (latch_s) begin
            rdata_r <= dmem.dmem_rdata;
        end
    end

    load_align u_load_align (
        .rdata         (rdata_r),
        .addr          (held_r.ex_result[1:0]),
        .number_length (held_r.number_length),
        .result        (align_s)
    );

    // Request payload; zero whenever no request is being offered
    always_comb begin
        dmem.dmem_req_valid = 1'b0;
        dmem.dmem_req_we    = 1'b0;
        dmem.dmem_addr      = 32'h0000_0000;
        dmem.dmem_wdata     = 32'h0000_0000;
        dmem.dmem_wstrb     = 4'b0000;
        if (state_r == ST_REQ) begin
            dmem.dmem_req_valid = 1'b1;
            dmem.dmem_req_we    = held_r.mem_write;
            dmem.dmem_addr      = {held_r.ex_result[31:2], 2'b00};
            case (size_e'(held_r.number_length[1:0]))
                SIZE_BYTE: begin
                    dmem.dmem_wdata = {4{held_r.store_data[7:0]}};
                    dmem.dmem_wstrb = held_r.mem_write ? (4'b0001 << held_r.ex_result[1:0]) : 4'b0000;
                end
                SIZE_HALF: begin
                    dmem.dmem_wdata = {2{held_r.store_data[15:0]}};
                    dmem.dmem_wstrb = held_r.mem_write ? (4'b0011 << held_r.ex_result[1:0]) : 4'b0000;
                end
                default: begin
                    dmem.dmem_wdata = held_r.store_data;
                    dmem.dmem_wstrb = held_r.mem_write ? 4'b1111 : 4'b0000;
                end
            endcase
        end else begin
            dmem.dmem_req_valid = 1'b0;
        end
    end

    // Writeback-facing view of the held instruction
    always_comb begin
        stall           = (state_r == ST_REQ) || (state_r == ST_RESP) || (state_r == ST_DRAIN);
        ex_result       = held_r.ex_result;
        rd_index        = held_r.rd_index;
        number_length   = held_r.number_length;
        writeback_src   = held_r.wb_src;
        ale             = held_r.ale;
        writeback_valid = held_r.wb_valid && !held_r.ale &&
                          ((state_r == ST_IDLE) || (state_r == ST_DONE));
        if ((state_r == ST_DONE) && held_r.mem_read && !held_r.ale) begin
            mem_result = align_s;
        end else begin
            mem_result = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table driven through a
// memory responder, results checked through a scoreboard queue, plus
// hand-written flush and reset sequences.
module tb_memory_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ex_in, sd_in;
    logic [4:0]  rd_in;
    logic [2:0]  nl_in;
    logic        mrd_in, mwr_in, wbv_in, src_in, clr_in;
    logic        stall;
    logic [31:0] ex_result, mem_result;
    logic [4:0]  rd_index;
    logic [2:0]  number_length;
    logic        writeback_valid, writeback_src, ale;

    memory_stage_if bus ();

    memory_stage dut (
        .clk(clk), .rstn(rstn),
        .ex_result_RegInput(ex_in), .store_data_RegInput(sd_in),
        .rd_index_RegInput(rd_in), .number_length_RegInput(nl_in),
        .mem_read_RegInput(mrd_in), .mem_write_RegInput(mwr_in),
        .writeback_valid_RegInput(wbv_in), .writeback_src_RegInput(src_in),
        .clear_RegInput(clr_in), .stall(stall), .dmem(bus),
        .ex_result(ex_result), .mem_result(mem_result), .rd_index(rd_index),
        .number_length(number_length), .writeback_valid(writeback_valid),
        .writeback_src(writeback_src), .ale(ale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ex;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  nl;
        logic        rd_op;
        logic        wr_op;
        logic        wbv;
        logic        src;
        logic [31:0] rdata;
        logic        bus_op;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_mem;
        logic        e_ale;
        logic        e_wbv;
    } vec_t;

    typedef struct {
        logic        wbv;
        logic [31:0] ex;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic        src;
        logic        ale;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle_inputs();
        ex_in = 32'h0; sd_in = 32'h0; rd_in = 5'd0; nl_in = 3'd0;
        mrd_in = 1'b0; mwr_in = 1'b0; wbv_in = 1'b0; src_in = 1'b0; clr_in = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".stall"}, stall, 1'b0);
        chk({tag, ".req_valid"}, bus.dmem_req_valid, 1'b0);
        chk({tag, ".req_we"}, bus.dmem_req_we, 1'b0);
        chk({tag, ".wstrb"}, bus.dmem_wstrb, 4'b0000);
        chk({tag, ".addr"}, bus.dmem_addr, 32'h0);
        chk({tag, ".wdata"}, bus.dmem_wdata, 32'h0);
        chk({tag, ".ex_result"}, ex_result, 32'h0);
        chk({tag, ".mem_result"}, mem_result, 32'h0);
        chk({tag, ".rd_index"}, rd_index, 5'd0);
        chk({tag, ".number_length"}, number_length, 3'd0);
        chk({tag, ".wb_valid"}, writeback_valid, 1'b0);
        chk({tag, ".wb_src"}, writeback_src, 1'b0);
        chk({tag, ".ale"}, ale, 1'b0);
    endtask

    // Pop the oldest expected writeback and compare against the outputs
    task automatic sb_check(input string tag);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s.sb: got output with empty scoreboard, expected a pending entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".wb_valid"}, writeback_valid, e.wbv);
            chk({tag, ".ex_result"}, ex_result, e.ex);
            chk({tag, ".mem_result"}, mem_result, e.mem);
            chk({tag, ".rd_index"}, rd_index, e.rd);
            chk({tag, ".wb_src"}, writeback_src, e.src);
            chk({tag, ".ale"}, ale, e.ale);
        end
    endtask

    task automatic check_payload(input string tag, input vec_t v);
        chk({tag, ".stall"}, stall, 1'b1);
        chk({tag, ".req_valid"}, bus.dmem_req_valid, 1'b1);
        chk({tag, ".addr"}, bus.dmem_addr, v.e_addr);
        chk({tag, ".wdata"}, bus.dmem_wdata, v.e_wdata);
        chk({tag, ".wstrb"}, bus.dmem_wstrb, v.e_wstrb);
        chk({tag, ".req_we"}, bus.dmem_req_we, v.wr_op);
    endtask

    // One instruction through the stage; memory accepts after ready_wait cycles
    task automatic apply_vec(input string tag, input vec_t v, input int ready_wait);
        exp_t e;
        ex_in = v.ex; sd_in = v.sd; rd_in = v.rd; nl_in = v.nl;
        mrd_in = v.rd_op; mwr_in = v.wr_op; wbv_in = v.wbv; src_in = v.src; clr_in = 1'b0;
        e.wbv = v.e_wbv; e.ex = v.ex; e.mem = v.e_mem; e.rd = v.rd; e.src = v.src; e.ale = v.e_ale;
        sb_q.push_back(e);
        tick();
        drive_idle_inputs();
        if (v.bus_op) begin
            for (int i = 0; i < ready_wait; i++) begin
                check_payload({tag, ".wait"}, v);
                tick();
            end
            check_payload(tag, v);
            bus.dmem_req_ready = 1'b1;
            tick();
            bus.dmem_req_ready = 1'b0;
            chk({tag, ".resp_stall"}, stall, 1'b1);
            chk({tag, ".resp_req_valid"}, bus.dmem_req_valid, 1'b0);
            bus.dmem_rsp_valid = 1'b1;
            bus.dmem_rdata = v.rdata;
            tick();
            bus.dmem_rsp_valid = 1'b0;
            bus.dmem_rdata = 32'h0;
        end else begin
            chk({tag, ".req_valid"}, bus.dmem_req_valid, 1'b0);
        end
        chk({tag, ".done_stall"}, stall, 1'b0);
        sb_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //          ex            sd            rd     nl      rd    wr    wbv   src        rdata         bus   addr          wdata         wstrb    mem           ale   ewbv
        vecs[0]  = '{32'h0000_1234, 32'h0, 5'd5,  3'b010, 1'b0, 1'b0, 1'b1, WB_SRC_EX,  32'h0,        1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 1'b1};
        vecs[1]  = '{32'h0000_1003, 32'h0, 5'd6,  3'b000, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h80FF_0000, 1'b1, 32'h0000_1000, 32'h0,      4'b0000, 32'hFFFF_FF80, 1'b0, 1'b1};
        vecs[2]  = '{32'h0000_1003, 32'h0, 5'd6,  3'b100, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h80FF_0000, 1'b1, 32'h0000_1000, 32'h0,      4'b0000, 32'h0000_0080, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_2002, 32'h0, 5'd7,  3'b001, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h8001_7FFF, 1'b1, 32'h0000_2000, 32'h0,      4'b0000, 32'hFFFF_8001, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_2000, 32'h0, 5'd8,  3'b101, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h8001_F0F0, 1'b1, 32'h0000_2000, 32'h0,      4'b0000, 32'h0000_F0F0, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000_3004, 32'h0, 5'd9,  3'b010, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'hDEAD_BEEF, 1'b1, 32'h0000_3004, 32'h0,      4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_4001, 32'h1234_565A, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, WB_SRC_EX, 32'h0,   1'b1, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0010, 32'h0,     1'b0, 1'b0};
        vecs[7]  = '{32'h0000_4008, 32'hCAFE_F00D, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, WB_SRC_EX, 32'h0,   1'b1, 32'h0000_4008, 32'hCAFE_F00D, 4'b1111, 32'h0,     1'b0, 1'b0};
        vecs[8]  = '{32'h0000_3001, 32'h0, 5'd10, 3'b010, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h0,        1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
        vecs[9]  = '{32'h0000_2003, 32'h0, 5'd11, 3'b001, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h0,        1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{32'h0000_3006, 32'h0, 5'd12, 3'b011, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h0,        1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
        vecs[11] = '{32'h0000_3008, 32'h0, 5'd13, 3'b011, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h1357_9BDF, 1'b1, 32'h0000_3008, 32'h0,      4'b0000, 32'h1357_9BDF, 1'b0, 1'b1};
        vecs[12] = '{32'h0000_1000, 32'h0, 5'd14, 3'b000, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'hFFFF_FF7F, 1'b1, 32'h0000_1000, 32'h0,      4'b0000, 32'h0000_007F, 1'b0, 1'b1};

        rstn = 1'b0;
        drive_idle_inputs();
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rdata     = 32'h0;
        repeat (2) tick();
        check_reset_outs("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Vector table: one instruction per entry, memory answers immediately
        for (int i = 0; i < 13; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i], 0);
        end

        // SH with memory holding off acceptance for three cycles
        v = '{32'h0000_2002, 32'h0000_ABCD, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, WB_SRC_EX, 32'h0,
              1'b1, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0, 1'b0};
        apply_vec("sh_wait", v, 3);

        // Flush while the request is still being offered: dropped outright
        v = '{32'h0000_3000, 32'h0, 5'd3, 3'b010, 1'b1, 1'b0, 1'b1, WB_SRC_MEM, 32'h0,
              1'b1, 32'h0000_3000, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
        ex_in = v.ex; rd_in = v.rd; nl_in = v.nl; mrd_in = 1'b1; wbv_in = 1'b1; src_in = 1'b1;
        tick();
        drive_idle_inputs();
        chk("clr_req.req_valid_before", bus.dmem_req_valid, 1'b1);
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        chk("clr_req.req_valid", bus.dmem_req_valid, 1'b0);
        chk("clr_req.stall", stall, 1'b0);
        chk("clr_req.wb_valid", writeback_valid, 1'b0);

        // Flush after acceptance: stage drains the response, then a bubble
        ex_in = v.ex; rd_in = v.rd; nl_in = v.nl; mrd_in = 1'b1; wbv_in = 1'b1; src_in = 1'b1;
        tick();
        drive_idle_inputs();
        bus.dmem_req_ready = 1'b1;
        tick();
        bus.dmem_req_ready = 1'b0;
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        chk("drain.stall0", stall, 1'b1);
        chk("drain.wb_valid0", writeback_valid, 1'b0);
        chk("drain.req_valid0", bus.dmem_req_valid, 1'b0);
        tick();
        chk("drain.stall1", stall, 1'b1);
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata = 32'h7777_7777;
        tick();
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rdata = 32'h0;
        chk("drain.stall_end", stall, 1'b0);
        chk("drain.wb_valid_end", writeback_valid, 1'b0);
        chk("drain.mem_result_end", mem_result, 32'h0);
        v = '{32'h0000_0055, 32'h0, 5'd7, 3'b010, 1'b0, 1'b0, 1'b1, WB_SRC_EX, 32'h0,
              1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
        apply_vec("after_drain", v, 0);

        // Reset while a request is offered: request drops without a clock edge
        ex_in = 32'h0000_5000; rd_in = 5'd4; nl_in = 3'b010; mrd_in = 1'b1; wbv_in = 1'b1; src_in = 1'b1;
        tick();
        drive_idle_inputs();
        chk("rst_req.req_valid_before", bus.dmem_req_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outs("rst_req");
        @(negedge clk);
        rstn = 1'b1;
        tick();
        v = '{32'h0000_00AA, 32'h0, 5'd1, 3'b010, 1'b0, 1'b0, 1'b1, WB_SRC_EX, 32'h0,
              1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
        apply_vec("after_rst", v, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
